// File: rtl/dc_adpcm_sched.sv
// rtl/dc_adpcm_sched.sv - line scheduler feeding FIFO words to the ADPCM decoder
module dc_adpcm_sched #(
    parameter int LINE_WORDS = 1280,
    parameter int KEY_INT    = 16,
    parameter int CW         = 11
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        line_start,
    input  logic        dn_ready,
    input  logic        fifo_empty,
    input  logic [15:0] fifo_dout,
    input  logic        clr_err,
    output logic        fifo_rd,
    output logic        dc_en,
    output logic        dc_eo,
    output logic        dc_sel,
    output logic [15:0] dc_din,
    output logic        line_done,
    output logic        busy,
    output logic        err_under,
    output logic        err_sync
);

    localparam int KB = $clog2(KEY_INT);
    localparam logic [CW-1:0] LAST_IDX = CW'(LINE_WORDS - 1);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    logic [0:0]    state;
    logic [CW-1:0] wcnt;
    logic          run;
    logic          issue;
    logic          last;
    logic          under;

    // A word moves only when in RUN, downstream is ready and the FIFO has data.
    assign run     = (state == S_RUN);
    assign issue   = run & dn_ready & ~fifo_empty;
    assign last    = issue & (wcnt == LAST_IDX);
    assign under   = run & dn_ready & fifo_empty;
    assign fifo_rd = issue;
    assign busy    = run;

    // Output register: capture the FIFO head and its raw/differential marker on issue.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dc_din    <= '0;
            dc_eo     <= 1'b0;
            dc_en     <= 1'b0;
            dc_sel    <= 1'b0;
            line_done <= 1'b0;
        end else begin
            if (issue) begin
                dc_din <= fifo_dout;
                dc_eo  <= (wcnt[KB-1:0] != '0);
            end
            dc_en     <= issue;
            dc_sel    <= dc_eo;
            line_done <= last;
        end
    end

    // Line state and word counter; a line_start coinciding with the last word opens a fresh line.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            wcnt  <= '0;
        end else if (!run) begin
            if (line_start) begin
                state <= S_RUN;
                wcnt  <= '0;
            end
        end else if (last) begin
            state <= line_start ? S_RUN : S_IDLE;
            wcnt  <= '0;
        end else if (line_start) begin
            wcnt  <= '0;
        end else if (issue) begin
            wcnt  <= wcnt + 1'b1;
        end
    end

    // Sticky error flags; clearing wins over a simultaneous set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_under <= 1'b0;
            err_sync  <= 1'b0;
        end else begin
            if (clr_err)
                err_under <= 1'b0;
            else if (under)
                err_under <= 1'b1;
            if (clr_err)
                err_sync <= 1'b0;
            else if (run & line_start & ~last)
                err_sync <= 1'b1;
        end
    end

endmodule

// File: tb/tb_dc_adpcm_sched.sv
// tb/tb_dc_adpcm_sched.sv - directed self-checking bench for dc_adpcm_sched
module tb_dc_adpcm_sched;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        line_start = 1'b0;
    logic        dn_ready = 1'b0;
    logic        fifo_empty;
    logic [15:0] fifo_dout;
    logic        clr_err = 1'b0;
    logic        fifo_rd;
    logic        dc_en;
    logic        dc_eo;
    logic        dc_sel;
    logic [15:0] dc_din;
    logic        line_done;
    logic        busy;
    logic        err_under;
    logic        err_sync;

    int errors = 0;
    int checks = 0;

    dc_adpcm_sched #(.LINE_WORDS(32), .KEY_INT(16), .CW(11)) dut (
        .clk(clk), .rst(rst), .line_start(line_start), .dn_ready(dn_ready),
        .fifo_empty(fifo_empty), .fifo_dout(fifo_dout), .clr_err(clr_err),
        .fifo_rd(fifo_rd), .dc_en(dc_en), .dc_eo(dc_eo), .dc_sel(dc_sel),
        .dc_din(dc_din), .line_done(line_done), .busy(busy),
        .err_under(err_under), .err_sync(err_sync)
    );

    always #5 clk = ~clk;

    // FIFO model: word k holds value k; fill sets how many words exist.
    int   rd_ptr = 0;
    int   fill = 0;
    logic fifo_prime = 1'b0;
    logic hold_empty = 1'b0;

    always @(posedge clk) begin
        if (fifo_prime) rd_ptr <= 0;
        else if (fifo_rd) rd_ptr <= rd_ptr + 1;
    end

    assign fifo_empty = hold_empty || (rd_ptr >= fill);
    assign fifo_dout  = 16'(rd_ptr);

    // Output log, captured away from the active edge.
    int          n = 0;
    int          cyc = 0;
    int          done_cnt = 0;
    int          done_at = 0;
    int          sel_bad = 0;
    int          rd_bad = 0;
    logic        prev_eo = 1'b0;
    logic [15:0] log_din [0:511];
    logic        log_eo  [0:511];
    int          log_cyc [0:511];

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (rst) begin
            prev_eo = 1'b0;
        end else begin
            if (dc_en) begin
                log_din[n] = dc_din;
                log_eo[n]  = dc_eo;
                log_cyc[n] = cyc;
                n = n + 1;
            end
            if (line_done) begin
                done_cnt = done_cnt + 1;
                done_at  = n;
            end
            if (dc_sel !== prev_eo) sel_bad = sel_bad + 1;
            prev_eo = dc_eo;
            if (fifo_rd && (fifo_empty || !busy)) rd_bad = rd_bad + 1;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_line(input int f);
        fill = f;
        fifo_prime = 1'b1;
        step();
        fifo_prime = 1'b0;
        line_start = 1'b1;
        step();
        line_start = 1'b0;
    endtask

    task automatic wait_idle(input string nm);
        int k = 0;
        while (busy && k < 300) begin
            step();
            k++;
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL %s_timeout: busy=%b required 0", nm, busy);
        end
        step();
        step();
    endtask

    task automatic wait_ptr(input int p, input string nm);
        int k = 0;
        while (rd_ptr != p && k < 300) begin
            step();
            k++;
        end
        checks++;
        if (rd_ptr != p) begin
            errors++;
            $display("FAIL %s_ptr_timeout: rd_ptr=%0d required %0d", nm, rd_ptr, p);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        checks++;
        if ({fifo_rd, dc_en, dc_eo, dc_sel, dc_din, line_done, busy, err_under, err_sync} !== 25'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %h required 0",
                     {fifo_rd, dc_en, dc_eo, dc_sel, dc_din, line_done, busy, err_under, err_sync});
        end
        rst = 1'b0;
        dn_ready = 1'b1;
        step();
        checks++;
        if ({busy, fifo_rd, dc_en} !== 3'b000) begin
            errors++;
            $display("FAIL reset_idle: busy/rd/en=%b required 000", {busy, fifo_rd, dc_en});
        end
    endtask

    task automatic test_full_line();
        int base, d0, bad_din, bad_eo;
        base = n;
        d0 = done_cnt;
        dn_ready = 1'b1;
        start_line(32);
        wait_idle("full");
        bad_din = 0;
        bad_eo = 0;
        for (int i = 0; i < 32; i++) begin
            if (log_din[base+i] !== 16'(i)) bad_din++;
            if (log_eo[base+i] !== ((i % 16) != 0)) bad_eo++;
        end
        checks++;
        if (n - base != 32) begin errors++; $display("FAIL full_count: got %0d required 32", n - base); end
        checks++;
        if (bad_din != 0) begin errors++; $display("FAIL full_din_order: bad=%0d required 0", bad_din); end
        checks++;
        if (bad_eo != 0) begin errors++; $display("FAIL full_eo_keys: bad=%0d required 0", bad_eo); end
        checks++;
        if (log_cyc[base+31] - log_cyc[base] != 31) begin
            errors++;
            $display("FAIL full_back_to_back: span=%0d required 31", log_cyc[base+31] - log_cyc[base]);
        end
        checks++;
        if (done_cnt - d0 != 1 || done_at - base != 32) begin
            errors++;
            $display("FAIL full_line_done: pulses=%0d at=%0d required 1 at 32", done_cnt - d0, done_at - base);
        end
        checks++;
        if ({err_under, err_sync} !== 2'b00) begin
            errors++;
            $display("FAIL full_errs: got %b required 00", {err_under, err_sync});
        end
    endtask

    task automatic test_throttled();
        int base, d0, bad_din, bad_gap, k;
        base = n;
        d0 = done_cnt;
        dn_ready = 1'b1;
        start_line(32);
        k = 0;
        while (busy && k < 300) begin
            dn_ready = ~dn_ready;
            step();
            k++;
        end
        dn_ready = 1'b1;
        wait_idle("throttle");
        bad_din = 0;
        bad_gap = 0;
        for (int i = 0; i < 32; i++) begin
            if (log_din[base+i] !== 16'(i)) bad_din++;
            if (i > 0 && log_cyc[base+i] - log_cyc[base+i-1] != 2) bad_gap++;
        end
        checks++;
        if (n - base != 32) begin errors++; $display("FAIL thr_count: got %0d required 32", n - base); end
        checks++;
        if (bad_din != 0) begin errors++; $display("FAIL thr_din_order: bad=%0d required 0", bad_din); end
        checks++;
        if (bad_gap != 0) begin errors++; $display("FAIL thr_gap: bad=%0d required 0", bad_gap); end
        checks++;
        if (done_cnt - d0 != 1 || {err_under, err_sync} !== 2'b00) begin
            errors++;
            $display("FAIL thr_done_errs: pulses=%0d errs=%b required 1, 00", done_cnt - d0, {err_under, err_sync});
        end
    endtask

    task automatic test_underrun();
        int base, d0, bad_din, bad_eo;
        base = n;
        d0 = done_cnt;
        dn_ready = 1'b1;
        start_line(32);
        wait_ptr(5, "under");
        hold_empty = 1'b1;
        step();
        step();
        step();
        hold_empty = 1'b0;
        checks++;
        if (err_under !== 1'b1) begin errors++; $display("FAIL under_flag: got %b required 1", err_under); end
        wait_idle("under");
        bad_din = 0;
        bad_eo = 0;
        for (int i = 0; i < 32; i++) begin
            if (log_din[base+i] !== 16'(i)) bad_din++;
            if (log_eo[base+i] !== ((i % 16) != 0)) bad_eo++;
        end
        checks++;
        if (n - base != 32 || bad_din != 0) begin
            errors++;
            $display("FAIL under_words: count=%0d bad=%0d required 32, 0", n - base, bad_din);
        end
        checks++;
        if (bad_eo != 0 || log_eo[base+16] !== 1'b0) begin
            errors++;
            $display("FAIL under_keys: bad=%0d eo16=%b required 0, 0", bad_eo, log_eo[base+16]);
        end
        checks++;
        if (done_cnt - d0 != 1 || done_at - base != 32) begin
            errors++;
            $display("FAIL under_done: pulses=%0d at=%0d required 1 at 32", done_cnt - d0, done_at - base);
        end
        clr_err = 1'b1;
        step();
        clr_err = 1'b0;
        checks++;
        if (err_under !== 1'b0) begin errors++; $display("FAIL under_clear: got %b required 0", err_under); end
    endtask

    task automatic test_resync();
        int base, d0;
        base = n;
        d0 = done_cnt;
        dn_ready = 1'b1;
        start_line(64);
        wait_ptr(10, "sync");
        line_start = 1'b1;
        step();
        line_start = 1'b0;
        checks++;
        if (err_sync !== 1'b1) begin errors++; $display("FAIL sync_flag: got %b required 1", err_sync); end
        wait_idle("sync");
        checks++;
        if (n - base != 43) begin errors++; $display("FAIL sync_count: got %0d required 43", n - base); end
        checks++;
        if (log_din[base+10] !== 16'h000a || log_eo[base+10] !== 1'b1) begin
            errors++;
            $display("FAIL sync_old_word: din=%h eo=%b required 000a, 1", log_din[base+10], log_eo[base+10]);
        end
        checks++;
        if ({log_eo[base+11], log_eo[base+12], log_eo[base+27], log_eo[base+42]} !== 4'b0101) begin
            errors++;
            $display("FAIL sync_new_keys: got %b required 0101",
                     {log_eo[base+11], log_eo[base+12], log_eo[base+27], log_eo[base+42]});
        end
        checks++;
        if (done_cnt - d0 != 1 || done_at - base != 43) begin
            errors++;
            $display("FAIL sync_done: pulses=%0d at=%0d required 1 at 43", done_cnt - d0, done_at - base);
        end
        clr_err = 1'b1;
        step();
        clr_err = 1'b0;
        checks++;
        if (err_sync !== 1'b0) begin errors++; $display("FAIL sync_clear: got %b required 0", err_sync); end
    endtask

    task automatic test_clr_priority();
        int base, d0;
        base = n;
        d0 = done_cnt;
        dn_ready = 1'b1;
        start_line(32);
        wait_ptr(3, "clr");
        hold_empty = 1'b1;
        clr_err = 1'b1;
        step();
        clr_err = 1'b0;
        checks++;
        if (err_under !== 1'b0) begin errors++; $display("FAIL clr_priority: got %b required 0", err_under); end
        step();
        hold_empty = 1'b0;
        checks++;
        if (err_under !== 1'b1) begin errors++; $display("FAIL clr_reset_again: got %b required 1", err_under); end
        wait_idle("clr");
        checks++;
        if (n - base != 32 || done_cnt - d0 != 1) begin
            errors++;
            $display("FAIL clr_line: count=%0d pulses=%0d required 32, 1", n - base, done_cnt - d0);
        end
        clr_err = 1'b1;
        step();
        clr_err = 1'b0;
    endtask

    task automatic test_async_reset();
        int base, d0, bad_din, bad_eo;
        dn_ready = 1'b1;
        start_line(32);
        wait_ptr(7, "arst");
        rst = 1'b1;
        #1;
        checks++;
        if ({fifo_rd, dc_en, dc_eo, dc_sel, dc_din, line_done, busy, err_under, err_sync} !== 25'd0) begin
            errors++;
            $display("FAIL arst_outputs: got %h required 0",
                     {fifo_rd, dc_en, dc_eo, dc_sel, dc_din, line_done, busy, err_under, err_sync});
        end
        step();
        step();
        rst = 1'b0;
        step();
        base = n;
        d0 = done_cnt;
        start_line(32);
        wait_idle("arst");
        bad_din = 0;
        bad_eo = 0;
        for (int i = 0; i < 32; i++) begin
            if (log_din[base+i] !== 16'(i)) bad_din++;
            if (log_eo[base+i] !== ((i % 16) != 0)) bad_eo++;
        end
        checks++;
        if (n - base != 32 || bad_din != 0 || bad_eo != 0) begin
            errors++;
            $display("FAIL arst_new_line: count=%0d bad_din=%0d bad_eo=%0d required 32, 0, 0", n - base, bad_din, bad_eo);
        end
        checks++;
        if (done_cnt - d0 != 1) begin errors++; $display("FAIL arst_done: got %0d required 1", done_cnt - d0); end
    endtask

    task automatic test_invariants();
        checks++;
        if (sel_bad != 0) begin errors++; $display("FAIL sel_delay: bad=%0d required 0", sel_bad); end
        checks++;
        if (rd_bad != 0) begin errors++; $display("FAIL rd_guard: bad=%0d required 0", rd_bad); end
    endtask

    initial begin
        test_reset();
        test_full_line();
        test_throttled();
        test_underrun();
        test_resync();
        test_clr_priority();
        test_async_reset();
        test_invariants();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
